// File: rtl/seven_seg_scan_ctrl_if.sv
// Bundle of control inputs and display-side outputs for the seven-segment scan controller.
// The master drives load/enable/data; the slave (controller) drives the decoder and anodes.
interface seven_seg_scan_ctrl_if #(
  parameter int N_DIGITS = 4
);
  logic                    enable;
  logic                    lz_blank;
  logic                    load;
  logic [4*N_DIGITS-1:0]   data_in;
  logic [3:0]              BCD;
  logic                    Blanking;
  logic [N_DIGITS-1:0]     Anode;
  logic                    frame_done;
  logic                    update_pending;

  modport master (
    output enable, lz_blank, load, data_in,
    input  BCD, Blanking, Anode, frame_done, update_pending
  );

  modport slave (
    input  enable, lz_blank, load, data_in,
    output BCD, Blanking, Anode, frame_done, update_pending
  );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode display with
// frame-aligned word updates, leading-zero suppression and a per-slot anode guard.
module seven_seg_scan_ctrl #(
  parameter int N_DIGITS = 4,
  parameter int PRESCALE = 1000,
  parameter int GUARD    = 2
) (
  input logic                clock,
  input logic                reset,
  seven_seg_scan_ctrl_if.slave bus
);
  localparam int CW = $clog2(PRESCALE);
  localparam int KW = $clog2(N_DIGITS);
  localparam int DW = 4 * N_DIGITS;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [KW-1:0]       dig_q, dig_d;
  logic [DW-1:0]       active_q, active_d;
  logic [DW-1:0]       pending_q, pending_d;
  logic                pend_q, pend_d;
  logic [N_DIGITS-1:0] anode_q, anode_d;
  logic                blank_q, blank_d;
  logic                fdone_q, fdone_d;
  logic [3:0]          bcd_q, bcd_d;
  logic                last_cycle;
  logic [N_DIGITS-1:0] digit_zero;
  logic [N_DIGITS-1:0] upper_zero;

  assign last_cycle = (state_q == SCAN) && (cnt_q == CW'(PRESCALE - 1)) &&
                      (dig_q == KW'(N_DIGITS - 1));

  // upper_zero[k]: digits k..N_DIGITS-1 of the word being shown next cycle are all zero
  genvar gi;
  generate
    for (gi = 0; gi < N_DIGITS; gi++) begin : g_zero
      assign digit_zero[gi] = (active_d[4*gi +: 4] == 4'd0);
      assign upper_zero[gi] = &digit_zero[N_DIGITS-1:gi];
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dig_d     = dig_q;
    active_d  = active_q;
    pending_d = pending_q;
    pend_d    = pend_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        dig_d = '0;
        if (bus.load) active_d = bus.data_in;
        if (bus.enable) state_d = SCAN;
      end
      SCAN: begin
        if (!bus.enable) begin
          state_d = IDLE;
          cnt_d   = '0;
          dig_d   = '0;
        end else if (cnt_q == CW'(PRESCALE - 1)) begin
          cnt_d = '0;
          dig_d = (dig_q == KW'(N_DIGITS - 1)) ? '0 : dig_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        // At a frame boundary or on leaving SCAN a simultaneous load beats the older pending word
        if (last_cycle || !bus.enable) begin
          pend_d = 1'b0;
          if (bus.load)    active_d = bus.data_in;
          else if (pend_q) active_d = pending_q;
        end else if (bus.load) begin
          pending_d = bus.data_in;
          pend_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from next-state values so the registered pins line up with the counters
  always_comb begin
    anode_d = '1;
    blank_d = 1'b1;
    bcd_d   = 4'd0;
    fdone_d = 1'b0;
    if (state_d == SCAN) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        if (dig_d == KW'(i)) bcd_d = active_d[4*i +: 4];
      end
      if (cnt_d >= CW'(GUARD)) begin
        anode_d = ~(N_DIGITS'(1) << dig_d);
        blank_d = bus.lz_blank && (dig_d != '0) && upper_zero[dig_d];
      end
      fdone_d = (dig_d == KW'(N_DIGITS - 1)) && (cnt_d == CW'(PRESCALE - 1));
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dig_q     <= '0;
      active_q  <= '0;
      pending_q <= '0;
      pend_q    <= 1'b0;
      anode_q   <= '1;
      blank_q   <= 1'b1;
      bcd_q     <= 4'd0;
      fdone_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dig_q     <= dig_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      pend_q    <= pend_d;
      anode_q   <= anode_d;
      blank_q   <= blank_d;
      bcd_q     <= bcd_d;
      fdone_q   <= fdone_d;
    end
  end

  assign bus.BCD            = bcd_q;
  assign bus.Blanking       = blank_q;
  assign bus.Anode          = anode_q;
  assign bus.frame_done     = fdone_q;
  assign bus.update_pending = pend_q;
endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for an N-digit common-anode seven-segment display.
- Holds a BCD word for the whole display and steps through the digits one at a time. For each digit it presents the 4-bit BCD value and a Blanking flag to the shared BCD-to-seven-segment decoder, and drives the digit anode enables.
- Provides tear-free updates (a new word takes effect only at a frame boundary), leading-zero suppression, and a per-slot guard interval against ghosting.

Parameters:
- N_DIGITS, 4, number of digits scanned (2..8).
- PRESCALE, 1000, clock cycles per digit slot (must be > GUARD).
- GUARD, 2, cycles at the start of each slot with all anodes off and Blanking=1 (must be >= 1).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  1 = scanning; 0 = display dark.
- lz_blank  input  1  1 = suppress leading zeros.
- load  input  1  single-cycle strobe; captures data_in.
- data_in  input  4*N_DIGITS  BCD digits; digit k = bits [4k+3:4k]; digit 0 = least significant.
- BCD  output  4  digit value to the decoder.
- Blanking  output  1  to the decoder; 1 = segments off.
- Anode  output  N_DIGITS  active-low digit enables; bit k drives digit k.
- frame_done  output  1  one-cycle pulse on the last cycle of the digit N_DIGITS-1 slot.
- update_pending  output  1  1 = a loaded word is waiting for the frame boundary.

Behaviour:
- Reset (asynchronous, active-low):
  - Anode = all 1s; Blanking = 1; BCD = 0; frame_done = 0; update_pending = 0.
  - Active and pending registers = 0; slot counter = 0; digit index = 0; FSM = IDLE.
- All outputs are registered.
- FSM, state IDLE:
  - Anode all 1s, Blanking = 1; counters held at 0.
  - enable = 1 sampled at an edge -> SCAN. The first cycle of the digit-0 slot is the next cycle.
- FSM, state SCAN:
  - Slot counter c runs 0..PRESCALE-1. It wraps to 0 and the digit index k advances 0 -> 1 -> ... -> N_DIGITS-1 -> 0.
  - Cycles with c < GUARD: Anode = all 1s, Blanking = 1, BCD = active digit k.
  - Cycles with c >= GUARD: Anode = ~(1<<k), BCD = active digit k, Blanking = lz(k).
  - enable = 0 sampled in SCAN: return to IDLE on the next cycle; counters cleared; outputs take IDLE values.
- Leading-zero rule:
  - lz(k) = lz_blank AND k != 0 AND active digits k..N_DIGITS-1 are all 0.
  - Digit 0 is never suppressed, so an all-zero word shows "0".
- Values 10..15 are passed to BCD unchanged with Blanking = 0. The decoder blanks them. They count as non-zero for the lz rule.
- Frame timing:
  - Frame length = N_DIGITS*PRESCALE cycles.
  - frame_done = 1 exactly when k = N_DIGITS-1 and c = PRESCALE-1, SCAN only.
- Load and update rules:
  - load in IDLE: data_in is written directly to the active register; update_pending stays 0.
  - load in SCAN: data_in is written to the pending register; update_pending = 1 from the next cycle.
  - On the frame_done cycle, if update_pending = 1: active <= pending, update_pending <= 0. The new word is displayed from the first cycle of the following digit-0 slot.
  - load coinciding with the frame_done cycle: data_in goes directly to active; update_pending is cleared. The simultaneous load wins over any older pending word.
  - Repeated loads within one frame: the last load wins (pending is overwritten).
  - enable falling while update_pending = 1: pending is transferred to active on entering IDLE; update_pending is cleared.
- Reset asserted mid-frame: all state returns immediately (asynchronously) to the reset values; any pending word is lost.

Test Plan:
(N_DIGITS=4, PRESCALE=8, GUARD=1)
- Reset then enable=1 with active=0x1234, lz_blank=0 -> slot 0: 1 cycle with Anode=1111, Blanking=1, then 7 cycles with Anode=1110, BCD=4, Blanking=0. Slots 1..3 show BCD 3, 2, 1 on anodes 1101, 1011, 0111. frame_done pulses at cycle 31 of the frame.
- lz_blank=1: word 0x0050 -> digits 3 and 2 have Blanking=1; digits 1 and 0 show 5 and 0. Word 0x0000 -> only digit 0 unblanked, showing 0.
- load 0x9876 at cycle 10 of a frame displaying 0x1234 -> update_pending=1 until the frame_done cycle. The remainder of the current frame still shows 1234; the next frame shows 9876 starting with digit 0 = 6.
- load 0x1111 then 0x2222 in the same frame, plus a load of 0x3333 on the frame_done cycle -> next frame shows 3333; update_pending=0 after the boundary.
- enable 1 -> 0 in the middle of the digit-2 slot -> Anode=1111 and Blanking=1 from the next cycle. Re-enabling restarts at digit 0 with c=0.
- reset asserted asynchronously between clock edges mid-scan -> Anode=1111, Blanking=1, BCD=0, update_pending=0 immediately, without waiting for a clock edge. The word 0xA5C3 shows BCD 10 and 12 passed through unchanged with Blanking=0.
